// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multicycle core running 16-bit instructions over a single-port req/ack memory.
// Define MULTICYCLE_CPU_EXT_EN to enable SUB (op 6) and JZ (op 7); otherwise both execute as NOP.
module multicycle_cpu #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_bus_t;

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_HALT = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
`ifdef MULTICYCLE_CPU_EXT_EN
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
`endif

  state_t                  state_q, state_d;
  mem_bus_t                bus_q, bus_d;
  logic [ADDR_W-1:0]       pc_q, pc_d, pc_inc, data_addr;
  logic [15:0]             inst_q, inst_d;
  logic [DATA_W-1:0]       opa_q, opa_d, opb_q, opb_d;
  logic                    retire_q, retire_d, halted_q, halted_d;
  logic [15:0][DATA_W-1:0] rf;
  logic                    rf_we;
  logic [3:0]              rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic [3:0]              op;
  logic                    fin;

  assign op        = inst_q[15:12];
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign data_addr = ADDR_W'(inst_q[11:4]);

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    retire_d = 1'b0;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_waddr = inst_q[3:0];
    rf_wdata = '0;
    fin      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // First fetch after reset has no request in flight yet.
        if (!bus_q.req) begin
          bus_d.req  = 1'b1;
          bus_d.we   = 1'b0;
          bus_d.addr = pc_q;
        end else if (mem_ack) begin
          inst_d    = mem_rdata[15:0];
          bus_d.req = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = rf[inst_q[11:8]];
        opb_d   = rf[inst_q[7:4]];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_MOV: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(inst_q[11:4]);
            pc_d     = pc_inc;
            fin      = 1'b1;
          end
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = opa_q + opb_q;
            pc_d     = pc_inc;
            fin      = 1'b1;
          end
          OP_JMP: begin
            pc_d = ADDR_W'(inst_q[11:0]);
            fin  = 1'b1;
          end
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            retire_d = 1'b1;
          end
          OP_LD: begin
            bus_d.req  = 1'b1;
            bus_d.we   = 1'b0;
            bus_d.addr = data_addr;
            state_d    = S_MEM;
          end
          OP_ST: begin
            bus_d.req   = 1'b1;
            bus_d.we    = 1'b1;
            bus_d.addr  = data_addr;
            bus_d.wdata = rf[inst_q[3:0]];
            state_d     = S_MEM;
          end
`ifdef MULTICYCLE_CPU_EXT_EN
          OP_SUB: begin
            rf_we    = 1'b1;
            rf_wdata = opa_q - opb_q;
            pc_d     = pc_inc;
            fin      = 1'b1;
          end
          OP_JZ: begin
            pc_d = (opa_q == '0) ? ADDR_W'(inst_q[7:0]) : pc_inc;
            fin  = 1'b1;
          end
`endif
          default: begin
            pc_d = pc_inc;
            fin  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          bus_d.req = 1'b0;
          bus_d.we  = 1'b0;
          if (op == OP_LD) begin
            opa_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            pc_d = pc_inc;
            fin  = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = opa_q;
        pc_d     = pc_inc;
        fin      = 1'b1;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
    // Completing an instruction launches the next fetch in the same edge.
    if (fin) begin
      state_d    = S_FETCH;
      retire_d   = 1'b1;
      bus_d.req  = 1'b1;
      bus_d.we   = 1'b0;
      bus_d.addr = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      bus_q    <= '0;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     rf <= '0;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign mem_req   = bus_q.req;
  assign mem_we    = bus_q.we;
  assign mem_addr  = bus_q.addr;
  assign mem_wdata = bus_q.wdata;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed and random programs checked against an instruction-level model
// with a wait-state memory (addresses below 0x100 use data_wait, others fetch_wait).
module tb_multicycle_cpu;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam logic [AW-1:0] RPC = 12'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req, mem_we, mem_ack, retire, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_pass = 0;
  int fetch_wait = 0;
  int data_wait = 0;
  int wcnt = 0;
  int got_lat[$];

  logic [15:0]   mem [0:4095];
  logic [15:0]   mm  [0:4095];
  logic [15:0]   mr  [16];
  logic [AW-1:0] exp_pc_q[$];
  int            exp_lat_q[$];

  always #5 clk = ~clk;

  multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .retire(retire), .halted(halted)
  );

  assign mem_ack   = mem_req && (wcnt >= ((mem_addr < 12'h100) ? data_wait : fetch_wait));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      wcnt <= 0;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end else if (mem_req) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  function automatic int wt(input logic [AW-1:0] a);
    return (a < 12'h100) ? data_wait : fetch_wait;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h3000;
  endtask

  // Instruction-set interpreter: expected pc after each retire and its cycle cost.
  task automatic model_run();
    logic [AW-1:0] p;
    logic [15:0]   in;
    int            lat;
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    for (int i = 0; i < 16; i++) mr[i] = 16'h0;
    exp_pc_q.delete();
    exp_lat_q.delete();
    p = RPC;
    for (int s = 0; s < 2000; s++) begin
      in  = mm[p];
      lat = 3 + wt(p);
      case (in[15:12])
        4'd0: begin mr[in[3:0]] = {8'h00, in[11:4]}; p = p + 1; end
        4'd1: begin mr[in[3:0]] = mr[in[11:8]] + mr[in[7:4]]; p = p + 1; end
        4'd2: p = in[11:0];
        4'd3: begin exp_pc_q.push_back(p); exp_lat_q.push_back(lat); return; end
        4'd4: begin lat += 2 + wt({4'h0, in[11:4]}); mr[in[3:0]] = mm[in[11:4]]; p = p + 1; end
        4'd5: begin lat += 1 + wt({4'h0, in[11:4]}); mm[in[11:4]] = mr[in[3:0]]; p = p + 1; end
`ifdef MULTICYCLE_CPU_EXT_EN
        4'd6: begin mr[in[3:0]] = mr[in[11:8]] - mr[in[7:4]]; p = p + 1; end
        4'd7: p = (mr[in[11:8]] == 16'h0) ? {4'h0, in[7:0]} : p + 1;
`endif
        default: p = p + 1;
      endcase
      exp_pc_q.push_back(p);
      exp_lat_q.push_back(lat);
    end
  endtask

  // Runs the program in mem from RESET_PC to HALT, checking retire timing, pc and bus holds.
  task automatic run_prog(input string tag, input bit do_rst);
    int cyc, last, bad, el;
    bit first, ok, pr_req, pr_ack, pr_we;
    logic [AW-1:0] pr_addr, ep;
    logic [15:0] pr_wd;
    model_run();
    got_lat.delete();
    if (do_rst) begin
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
    end
    rst_n = 1'b1;
    cyc = 0; last = 0; first = 1'b1;
    pr_req = 1'b0; pr_ack = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wd = '0;
    while (halted !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (pr_req) begin
        n_chk++;
        if (pr_ack) ok = (mem_req === 1'b0) || (mem_we === 1'b0 && mem_addr === pc);
        else ok = (mem_req === 1'b1) && (mem_addr === pr_addr) && (mem_we === pr_we) &&
                  (!pr_we || mem_wdata === pr_wd);
        if (!ok) $display("FAIL %s bus_hold cyc %0d: req=%b we=%b addr=%h, required hold of addr=%h we=%b",
                          tag, cyc, mem_req, mem_we, mem_addr, pr_addr, pr_we);
        else n_pass++;
      end
      if (retire === 1'b1) begin
        got_lat.push_back(cyc - last);
        n_chk++;
        if (exp_pc_q.size() == 0) $display("FAIL %s extra_retire cyc %0d: pc=%h, none required", tag, cyc, pc);
        else begin
          ep = exp_pc_q.pop_front();
          el = exp_lat_q.pop_front() + (first ? 1 : 0);
          if (pc !== ep) $display("FAIL %s retire_pc cyc %0d: got %h required %h", tag, cyc, pc, ep);
          else n_pass++;
          n_chk++;
          if (cyc - last != el) $display("FAIL %s retire_gap cyc %0d: got %0d required %0d", tag, cyc, cyc - last, el);
          else n_pass++;
        end
        last = cyc; first = 1'b0;
      end
      pr_req = mem_req; pr_ack = mem_ack; pr_we = mem_we; pr_addr = mem_addr; pr_wd = mem_wdata;
    end
    n_chk++;
    if (halted !== 1'b1 || exp_pc_q.size() != 0)
      $display("FAIL %s completion: halted=%b missing_retires=%0d, required halted=1 missing=0", tag, halted, exp_pc_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) begin
      if (bad == 0) $display("FAIL %s data_mem addr %h: got %h required %h", tag, i, mem[i], mm[i]);
      bad++;
    end
    n_chk++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_reset();
    clear_mem();
    fetch_wait = 0; data_wait = 0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if ({mem_req, mem_we, retire, halted} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 || pc !== RPC)
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h pc=%h retire=%b halted=%b, required zeros and pc=%h",
               mem_req, mem_we, mem_addr, mem_wdata, pc, retire, halted, RPC);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RPC)
      $display("FAIL reset_first_req: req=%b we=%b addr=%h, required 1 0 %h", mem_req, mem_we, mem_addr, RPC);
    else n_pass++;
  endtask

  task automatic test_mov_add();
    clear_mem();
    fetch_wait = 0; data_wait = 0;
    mem[12'h100] = 16'h02A3; mem[12'h101] = 16'h1334; mem[12'h102] = 16'h5E04;
    run_prog("mov_add", 1'b1);
    n_chk++;
    if (mem[12'h0E0] !== 16'h0054) $display("FAIL mov_add_r4: got %h required 0054", mem[12'h0E0]);
    else n_pass++;
    n_chk++;
    if (got_lat.size() < 2 || got_lat[1] != 3) $display("FAIL mov_add_gap: got %0d required 3", got_lat.size() > 1 ? got_lat[1] : -1);
    else n_pass++;
  endtask

  task automatic test_ld_st();
    clear_mem();
    fetch_wait = 0; data_wait = 2;
    mem[12'h010] = 16'hBEEF;
    mem[12'h100] = 16'h8000; mem[12'h101] = 16'h4101; mem[12'h102] = 16'h5111;
    run_prog("ld_st", 1'b1);
    n_chk++;
    if (mem[12'h011] !== 16'hBEEF) $display("FAIL ld_st_data: got %h required BEEF", mem[12'h011]);
    else n_pass++;
    n_chk++;
    if (got_lat.size() < 3 || got_lat[1] != 7 || got_lat[2] != 6)
      $display("FAIL ld_st_latency: got %0d/%0d required 7/6", got_lat.size() > 1 ? got_lat[1] : -1, got_lat.size() > 2 ? got_lat[2] : -1);
    else n_pass++;
  endtask

  task automatic test_jmp_halt();
    int reqs;
    clear_mem();
    fetch_wait = 0; data_wait = 0;
    mem[12'h100] = 16'h2005;
    run_prog("jmp_halt", 1'b1);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_req !== 1'b0 || halted !== 1'b1) reqs++;
    end
    n_chk++;
    if (pc !== 12'h005 || reqs != 0) $display("FAIL halt_quiet: pc=%h bad_cycles=%0d, required pc=005 bad=0", pc, reqs);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    fetch_wait = 1; data_wait = 0;
    mem[12'h100] = 16'h2FFF; mem[12'hFFF] = 16'h8000;
    run_prog("pc_wrap", 1'b1);
    n_chk++;
    if (pc !== 12'h000 || got_lat.size() != 3) $display("FAIL pc_wrap: pc=%h retires=%0d, required 000 and 3", pc, got_lat.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mem();
    fetch_wait = 0; data_wait = 4;
    mem[12'h100] = 16'h0075; mem[12'h101] = 16'h20F0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    k = 0;
    while (!(mem_req === 1'b1 && mem_addr === 12'h0F0) && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    n_chk++;
    if (mem_req !== 1'b1 || mem_ack !== 1'b0 || mem_addr !== 12'h0F0)
      $display("FAIL reset_mid_wait: req=%b ack=%b addr=%h, required 1 0 0F0", mem_req, mem_ack, mem_addr);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (mem_req !== 1'b0 || pc !== RPC) $display("FAIL reset_mid_abort: req=%b pc=%h, required 0 %h", mem_req, pc, RPC);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      mem[12'h100 + i] = 16'h5000 | ((16'h00E0 + 16'(i)) << 4) | 16'(i);
      mem[12'h0E0 + i] = 16'hFFFF;
    end
    mem[12'h110] = 16'h3000;
    run_prog("reset_mid", 1'b0);
    n_chk++;
    if (mem[12'h0E5] !== 16'h0000) $display("FAIL reset_mid_regs: r5 got %h required 0000", mem[12'h0E5]);
    else n_pass++;
  endtask

  task automatic test_ext();
`ifdef MULTICYCLE_CPU_EXT_EN
    localparam logic [AW-1:0] EXP_PC = 12'h020;
    localparam logic [15:0]   EXP_R2 = 16'h0000;
`else
    localparam logic [AW-1:0] EXP_PC = 12'h105;
    localparam logic [15:0]   EXP_R2 = 16'h0009;
`endif
    clear_mem();
    fetch_wait = 0; data_wait = 1;
    mem[12'h100] = 16'h0092; mem[12'h101] = 16'h0051; mem[12'h102] = 16'h6112;
    mem[12'h103] = 16'h5E52; mem[12'h104] = 16'h7220;
    run_prog("ext", 1'b1);
    n_chk++;
    if (pc !== EXP_PC || mem[12'h0E5] !== EXP_R2)
      $display("FAIL ext_sub_jz: pc=%h r2=%h, required %h %h", pc, mem[12'h0E5], EXP_PC, EXP_R2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] in;
    for (int it = 0; it < 5; it++) begin
      clear_mem();
      fetch_wait = $urandom_range(0, 2);
      data_wait  = $urandom_range(0, 2);
      for (int i = 12'h0C0; i < 12'h100; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 30; i++) begin
        case ($urandom_range(0, 5))
          0: in = {4'h0, 12'($urandom)};
          1: in = {4'h1, 12'($urandom)};
          2: in = {4'h4, 3'b110, 5'($urandom), 4'($urandom)};
          3: in = {4'h5, 3'b111, 5'($urandom), 4'($urandom)};
          4: in = {4'($urandom_range(8, 15)), 12'($urandom)};
          default: in = {4'h6, 12'($urandom)};
        endcase
        mem[12'h100 + i] = in;
      end
      for (int i = 0; i < 16; i++) mem[12'h11E + i] = 16'h5000 | ((16'h00E0 + 16'(i)) << 4) | 16'(i);
      mem[12'h12E] = 16'h3000;
      run_prog("random", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_mov_add();
    test_ld_st();
    test_jmp_halt();
    test_pc_wrap();
    test_reset_mid();
    test_ext();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
